// File: rtl/noc_port_arbiter.sv
// Round-robin arbiter with lock bursts feeding one registered output stage.
// It shares a router output link or the NI injection slot between N_REQ requesters.
package pa_noc;
   localparam int PACKET_WIDTH = 32;
endpackage

module noc_port_arbiter #(
   parameter int N_REQ    = 5,
   parameter int MAX_LOCK = 8
) (
   input  logic                                         i_clk,
   input  logic                                         i_srst,
   input  logic [N_REQ-1:0]                             i_reqValid,
   input  logic [N_REQ-1:0][pa_noc::PACKET_WIDTH-1:0]   i_reqPacket,
   input  logic [N_REQ-1:0]                             i_reqLock,
   output logic [N_REQ-1:0]                             o_reqReady,
   output logic                                         o_valid,
   output logic [pa_noc::PACKET_WIDTH-1:0]              o_packet,
   input  logic                                         i_ready,
   output logic [$clog2(N_REQ)-1:0]                     o_grantIdx,
   output logic                                         o_locked
);

   localparam int PACKET_WIDTH = pa_noc::PACKET_WIDTH;
   localparam int IDX_W        = $clog2(N_REQ);
   localparam int CNT_W        = $clog2(MAX_LOCK + 1);

   typedef enum logic {ARB, LOCK} state_t;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   ptr, ptr_nxt;
   logic [CNT_W-1:0]   lock_cnt, lock_cnt_nxt;
   logic [CNT_W-1:0]   cnt_inc;
   logic               can_load;
   logic               grant;
   logic [IDX_W-1:0]   win;
   logic [IDX_W-1:0]   cand;
   logic               found;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      if (idx == IDX_W'(N_REQ - 1)) return '0;
      else                          return idx + IDX_W'(1);
   endfunction

   assign can_load = !o_valid || i_ready;
   assign cnt_inc  = lock_cnt + CNT_W'(1);
   assign o_locked = (state == LOCK);

   // Stage 0: arbitration and handshake toward the requesters
   always_comb begin
      state_nxt    = state;
      ptr_nxt      = ptr;
      lock_cnt_nxt = lock_cnt;
      grant        = 1'b0;
      win          = ptr;
      cand         = ptr;
      found        = 1'b0;
      o_reqReady   = '0;

      if (!i_srst && can_load) begin
         case (state)
            ARB: begin
               for (int k = 0; k < N_REQ; k++) begin
                  if (!found && i_reqValid[cand]) begin
                     found = 1'b1;
                     win   = cand;
                  end
                  cand = next_idx(cand);
               end
               if (found) begin
                  grant           = 1'b1;
                  o_reqReady[win] = 1'b1;
                  if (i_reqLock[win] && MAX_LOCK > 1) begin
                     state_nxt    = LOCK;
                     lock_cnt_nxt = CNT_W'(1);
                     ptr_nxt      = win;
                  end else begin
                     ptr_nxt = next_idx(win);
                  end
               end
            end
            LOCK: begin
               // An owner that goes idle while the link could take a beat forfeits the lock.
               if (i_reqValid[ptr]) begin
                  grant           = 1'b1;
                  win             = ptr;
                  o_reqReady[ptr] = 1'b1;
                  lock_cnt_nxt    = cnt_inc;
                  if (!i_reqLock[ptr] || cnt_inc == CNT_W'(MAX_LOCK)) begin
                     state_nxt    = ARB;
                     ptr_nxt      = next_idx(ptr);
                     lock_cnt_nxt = '0;
                  end
               end else begin
                  state_nxt    = ARB;
                  ptr_nxt      = next_idx(ptr);
                  lock_cnt_nxt = '0;
               end
            end
            default: state_nxt = ARB;
         endcase
      end
   end

   // Stage 1: registered output toward the link
   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         state      <= ARB;
         ptr        <= '0;
         lock_cnt   <= '0;
         o_valid    <= 1'b0;
         o_packet   <= '0;
         o_grantIdx <= '0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         lock_cnt <= lock_cnt_nxt;
         if (grant) begin
            o_valid    <= 1'b1;
            o_packet   <= i_reqPacket[win];
            o_grantIdx <= win;
         end else if (i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

   a_ready_onehot : assert property (@(posedge i_clk) disable iff (i_srst)
      $onehot0(o_reqReady));
   a_ready_valid : assert property (@(posedge i_clk) disable iff (i_srst)
      (o_reqReady & ~i_reqValid) == '0);

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Scoreboard bench for noc_port_arbiter: a reference model predicts each grant,
// queues the expected packet and compares it when the output register loads.
module tb_noc_port_arbiter;

   localparam int N    = 5;
   localparam int MAXL = 8;
   localparam int PW   = pa_noc::PACKET_WIDTH;

   typedef struct {
      int              idx;
      logic [PW-1:0]   pkt;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  srst;
   logic [N-1:0]          reqv;
   logic [N-1:0][PW-1:0]  pkts;
   logic [N-1:0]          reqlock;
   logic [N-1:0]          ready_vec;
   logic                  valid;
   logic [PW-1:0]         packet;
   logic                  rdy;
   logic [2:0]            grant_idx;
   logic                  locked;

   int errors = 0;
   int checks = 0;

   int            pkt_val[N];
   exp_t          sb[$];
   int            m_ptr, m_cnt;
   logic          m_lock, m_valid;
   int            m_idx;
   logic [PW-1:0] m_pkt;

   always #5 clk = ~clk;

   noc_port_arbiter #(.N_REQ(N), .MAX_LOCK(MAXL)) dut (
      .i_clk       (clk),
      .i_srst      (srst),
      .i_reqValid  (reqv),
      .i_reqPacket (pkts),
      .i_reqLock   (reqlock),
      .o_reqReady  (ready_vec),
      .o_valid     (valid),
      .o_packet    (packet),
      .i_ready     (rdy),
      .o_grantIdx  (grant_idx),
      .o_locked    (locked)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic drive_pkts();
      for (int r = 0; r < N; r++) pkts[r] = PW'(pkt_val[r]);
   endtask

   // Called at a negedge with inputs already driven; returns at the next negedge.
   task automatic tick(output int g);
      int      gw;
      logic [N-1:0] er;
      exp_t    e;
      #2;
      gw = -1;
      er = '0;
      if (!srst && (!m_valid || rdy)) begin
         if (!m_lock) begin
            for (int k = 0; k < N; k++)
               if (gw < 0 && reqv[(m_ptr + k) % N]) gw = (m_ptr + k) % N;
         end else if (reqv[m_ptr]) begin
            gw = m_ptr;
         end
      end
      if (gw >= 0) er[gw] = 1'b1;
      chk("reqReady", ready_vec, er);
      g = -1;
      for (int r = 0; r < N; r++) if (ready_vec[r]) g = r;

      if (srst) begin
         m_ptr = 0; m_cnt = 0; m_lock = 0; m_valid = 0; m_idx = 0; m_pkt = '0;
         sb.delete();
      end else begin
         if (!m_valid || rdy) begin
            if (m_lock) begin
               if (gw < 0) begin
                  m_lock = 0; m_ptr = (m_ptr + 1) % N;
               end else begin
                  m_cnt++;
                  if (!reqlock[gw] || m_cnt == MAXL) begin
                     m_lock = 0; m_ptr = (gw + 1) % N;
                  end
               end
            end else if (gw >= 0) begin
               if (reqlock[gw] && MAXL > 1) begin
                  m_lock = 1; m_cnt = 1; m_ptr = gw;
               end else begin
                  m_ptr = (gw + 1) % N;
               end
            end
         end
         if (gw >= 0) begin
            e.idx = gw;
            e.pkt = pkts[gw];
            sb.push_back(e);
            m_valid = 1;
         end else if (rdy) begin
            m_valid = 0;
         end
      end

      @(posedge clk);
      #1;
      chk("o_valid", valid, m_valid);
      chk("o_locked", locked, m_lock);
      if (gw >= 0 && !srst) begin
         if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
         end else begin
            e = sb.pop_front();
            m_idx = e.idx;
            m_pkt = e.pkt;
         end
      end
      chk("o_grantIdx", grant_idx, m_idx);
      chk("o_packet", packet, m_pkt);
      if (gw >= 0) begin
         pkt_val[gw]++;
         drive_pkts();
      end
      @(negedge clk);
   endtask

   initial begin
      int g;
      int exp1[6] = '{0, 1, 2, 3, 4, 0};
      srst = 1'b1; reqv = '0; reqlock = '0; rdy = 1'b0;
      m_ptr = 0; m_cnt = 0; m_lock = 0; m_valid = 0; m_idx = 0; m_pkt = '0;
      for (int r = 0; r < N; r++) pkt_val[r] = (r + 1) << 16;
      drive_pkts();
      @(negedge clk);

      // reset with requests pending: nothing may be granted
      reqv = '1;
      tick(g); tick(g);
      chk("reset_valid", valid, 0);
      chk("reset_locked", locked, 0);
      chk("reset_packet", packet, 0);
      srst = 1'b0; rdy = 1'b1;

      // all requesters, no lock: plain rotation
      for (int i = 0; i < 6; i++) begin
         tick(g);
         chk("rr_grant", g, exp1[i]);
      end
      reqv = '0;
      tick(g); tick(g);

      // single requester, downstream stalled
      reqv = 5'b01000; pkt_val[3] = 'hA5; drive_pkts(); rdy = 1'b0;
      tick(g);
      chk("stall_first_grant", g, 3);
      reqv = '0;
      for (int i = 0; i < 4; i++) begin
         tick(g);
         chk("stall_no_grant", g, -1);
         chk("stall_packet", packet, 'hA5);
         chk("stall_idx", grant_idx, 3);
      end
      rdy = 1'b1;
      tick(g);
      chk("stall_release", valid, 0);

      // lock burst by requester 1 capped at MAX_LOCK
      reqv = 5'b00010; reqlock = 5'b00010;
      tick(g);
      chk("lock_grant1", g, 1);
      chk("lock_held1", locked, 1);
      reqv = '1;
      for (int i = 2; i <= MAXL; i++) begin
         tick(g);
         chk("lock_grant", g, 1);
         chk("lock_held", locked, (i < MAXL) ? 1 : 0);
      end
      tick(g);
      chk("lock_after", g, 2);
      reqlock = '0; reqv = '0;
      tick(g);

      // requester 4 locks then goes idle: lock drops, pointer wraps to 0
      reqv = 5'b10000; reqlock = 5'b10000;
      tick(g); chk("lk4_first", g, 4);
      tick(g); chk("lk4_second", g, 4);
      reqv = 5'b00011;
      tick(g);
      chk("lk4_idle_nogrant", g, -1);
      chk("lk4_dropped", locked, 0);
      reqv = 5'b10011;
      tick(g);
      chk("lk4_wrap", g, 0);
      reqv = '0; reqlock = '0;
      tick(g);

      // reset while a packet is held and the lock is owned
      reqv = 5'b00100; reqlock = 5'b00100; rdy = 1'b0;
      tick(g);
      chk("rst_pre_locked", locked, 1);
      chk("rst_pre_valid", valid, 1);
      srst = 1'b1; reqv = 5'b01010; reqlock = '0;
      tick(g);
      chk("rst_mid_valid", valid, 0);
      chk("rst_mid_locked", locked, 0);
      srst = 1'b0; rdy = 1'b1;
      tick(g);
      chk("rst_first_grant", g, 1);

      // requesters 0 and 2 with the pointer parked at 1
      reqv = 5'b00001;
      tick(g); chk("ptr_setup", g, 0);
      reqv = 5'b00101;
      tick(g); chk("ptr1_first", g, 2);
      tick(g); chk("ptr1_second", g, 0);
      reqv = '0;
      tick(g);

      // random traffic; a pending request holds its valid, lock and packet
      for (int i = 0; i < 400; i++) begin
         for (int r = 0; r < N; r++) begin
            if (!reqv[r] || g == r) begin
               reqv[r]    = ($urandom_range(0, 2) != 0);
               reqlock[r] = ($urandom_range(0, 3) == 0);
            end
         end
         rdy = ($urandom_range(0, 3) != 0);
         tick(g);
      end
      reqv = '0; reqlock = '0; rdy = 1'b1;
      tick(g); tick(g); tick(g);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
